// File: rtl/trng_ehr_pkg.sv
// Shared definitions for the TRNG entropy holding register collector:
// FSM state encoding and default geometry.
package trng_ehr_pkg;

    localparam int WORD_W_DEF    = 32;
    localparam int EHR_WORDS_DEF = 6;
    localparam int PTR_W_DEF     = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        FULL  = 2'b10,
        DRAIN = 2'b11
    } ehr_state_t;

endpackage

// File: rtl/trng_ehr_collector_if.sv
// Host-side read handshake and status of the EHR collector; the collector
// drives it through the slave modport, the host reader through master.
interface trng_ehr_collector_if
    import trng_ehr_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int PTR_W  = PTR_W_DEF
);

    logic              rd_req;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic              ehr_valid;
    logic              ehr_overflow;
    logic              vn_err_flag;
    logic [PTR_W-1:0]  ehr_word_cnt;

    modport master (
        output rd_req,
        input  rd_data, rd_valid, ehr_valid, ehr_overflow, vn_err_flag, ehr_word_cnt
    );

    modport slave (
        input  rd_req,
        output rd_data, rd_valid, ehr_valid, ehr_overflow, vn_err_flag, ehr_word_cnt
    );

endinterface

// File: rtl/trng_ehr_wordbuf.sv
// EHR word storage: one write port, one registered read port and a
// synchronous clear that also zeroes the read data register.
module trng_ehr_wordbuf
    import trng_ehr_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int EHR_WORDS = EHR_WORDS_DEF,
    parameter int PTR_W     = PTR_W_DEF
) (
    input  logic              rng_clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              we,
    input  logic [PTR_W-1:0]  wr_ptr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [EHR_WORDS];

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < EHR_WORDS; i++) mem[i] <= '0;
            rdata <= '0;
        end else if (clr) begin
            for (int i = 0; i < EHR_WORDS; i++) mem[i] <= '0;
            rdata <= '0;
        end else begin
            if (we) mem[wr_ptr] <= wdata;
            if (re) rdata <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/trng_ehr_collector.sv
// Packs the filtered TRNG bit stream into words, holds a full EHR until the
// host drains it, and flushes on von Neumann errors or enable loss in FILL.
module trng_ehr_collector
    import trng_ehr_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter int EHR_WORDS = EHR_WORDS_DEF,
    parameter int PTR_W     = PTR_W_DEF
) (
    input  logic                rng_clk,
    input  logic                rst_n,
    input  logic                rst_trng_logic,
    input  logic                rnd_src_en,
    input  logic                bit_valid,
    input  logic                bit_data,
    input  logic                vn_err,
    trng_ehr_collector_if.slave ehr
);

    localparam int CNT_W = $clog2(WORD_W);

    ehr_state_t        state;
    logic [WORD_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  word_cnt;
    logic              ehr_valid_q;
    logic              overflow_q;
    logic              vn_flag_q;
    logic              rd_valid_q;
    logic              collect;
    logic              word_done;
    logic              rd_accept;
    logic              last_read;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;

    // Only the low WORD_W-1 bits are stored; the incoming bit completes the word.
    assign wdata     = {shreg, bit_data};
    assign collect   = (state == FILL) && rnd_src_en && bit_valid && !vn_err && !rst_trng_logic;
    assign word_done = collect && (bit_cnt == CNT_W'(WORD_W - 1));
    assign rd_accept = ((state == FULL) || (state == DRAIN)) && ehr.rd_req
                       && !vn_err && !rst_trng_logic;
    assign last_read = rd_accept && (rd_ptr == PTR_W'(EHR_WORDS - 1));

    trng_ehr_wordbuf #(
        .WORD_W    (WORD_W),
        .EHR_WORDS (EHR_WORDS),
        .PTR_W     (PTR_W)
    ) u_wordbuf (
        .rng_clk (rng_clk),
        .rst_n   (rst_n),
        .clr     (rst_trng_logic),
        .we      (word_done),
        .wr_ptr  (wr_ptr),
        .wdata   (wdata),
        .re      (rd_accept),
        .rd_ptr  (rd_ptr),
        .rdata   (rdata)
    );

    always_ff @(posedge rng_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_cnt    <= '0;
            ehr_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            vn_flag_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else if (rst_trng_logic) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_cnt    <= '0;
            ehr_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            vn_flag_q   <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            if (vn_err && (state != IDLE)) begin
                shreg       <= '0;
                bit_cnt     <= '0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                word_cnt    <= '0;
                ehr_valid_q <= 1'b0;
                vn_flag_q   <= 1'b1;
                state       <= rnd_src_en ? FILL : IDLE;
            end else begin
                case (state)
                    IDLE: if (rnd_src_en) state <= FILL;
                    FILL: begin
                        if (!rnd_src_en) begin
                            shreg    <= '0;
                            bit_cnt  <= '0;
                            wr_ptr   <= '0;
                            word_cnt <= '0;
                            state    <= IDLE;
                        end else if (bit_valid) begin
                            shreg <= wdata[WORD_W-2:0];
                            if (word_done) begin
                                bit_cnt  <= '0;
                                wr_ptr   <= wr_ptr + 1'b1;
                                word_cnt <= word_cnt + 1'b1;
                                if (word_cnt == PTR_W'(EHR_WORDS - 1)) begin
                                    state       <= FULL;
                                    ehr_valid_q <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    // A held EHR survives enable loss; it is drained before returning to IDLE.
                    FULL, DRAIN: begin
                        if ((state == FULL) && bit_valid) overflow_q <= 1'b1;
                        if (last_read) begin
                            rd_ptr      <= '0;
                            wr_ptr      <= '0;
                            word_cnt    <= '0;
                            ehr_valid_q <= 1'b0;
                            state       <= rnd_src_en ? FILL : IDLE;
                        end else if (rd_accept) begin
                            rd_ptr <= rd_ptr + 1'b1;
                            state  <= DRAIN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ehr.rd_data      = rdata;
    assign ehr.rd_valid     = rd_valid_q;
    assign ehr.ehr_valid    = ehr_valid_q;
    assign ehr.ehr_overflow = overflow_q;
    assign ehr.vn_err_flag  = vn_flag_q;
    assign ehr.ehr_word_cnt = word_cnt;

endmodule

// File: tb/tb_trng_ehr_collector.sv
// Directed bench for trng_ehr_collector; read responses are checked by a
// scoreboard monitor decoupled from the stimulus process.
module tb_trng_ehr_collector;
    import trng_ehr_pkg::*;

    localparam int WORD_W    = 32;
    localparam int EHR_WORDS = 6;
    localparam int PTR_W     = 3;

    typedef struct {
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic rng_clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_trng_logic = 1'b0;
    logic rnd_src_en = 1'b0;
    logic bit_valid = 1'b0;
    logic bit_data = 1'b0;
    logic vn_err = 1'b0;

    exp_t expQ[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    logic [31:0] ovWords [6] = '{32'h8000_0000, 32'h1234_5678, 32'hDEAD_BEEF,
                                 32'h0000_0001, 32'hFFFF_FFFF, 32'h0F0F_0F0F};
    logic [31:0] vnWords [6] = '{32'hC001_D00D, 32'h0000_FFFF, 32'h5555_AAAA,
                                 32'h8765_4321, 32'h7FFF_FFFE, 32'h3C3C_C3C3};
    logic [31:0] srWords [6] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333,
                                 32'h4444_4444, 32'h5555_5555, 32'h6666_6666};

    trng_ehr_collector_if #(.WORD_W(WORD_W), .PTR_W(PTR_W)) ehr ();

    trng_ehr_collector #(
        .WORD_W    (WORD_W),
        .EHR_WORDS (EHR_WORDS),
        .PTR_W     (PTR_W)
    ) dut (
        .rng_clk        (rng_clk),
        .rst_n          (rst_n),
        .rst_trng_logic (rst_trng_logic),
        .rnd_src_en     (rnd_src_en),
        .bit_valid      (bit_valid),
        .bit_data       (bit_data),
        .vn_err         (vn_err),
        .ehr            (ehr)
    );

    always #5 rng_clk = ~rng_clk;

    always @(posedge rng_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    // Each accepted read must produce exactly one pulse, one cycle later, in order.
    always @(negedge rng_clk) begin : monitor
        exp_t e;
        if (rst_n && ehr.rd_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("rd_valid_unexpected", 32'(ehr.rd_valid), 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("rd_data", ehr.rd_data, e.word);
                checkOutput("rd_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end
    end

    task automatic applyStimulus(input logic bv, input logic bd, input logic req, input logic vn);
        bit_valid  = bv;
        bit_data   = bd;
        ehr.rd_req = req;
        vn_err     = vn;
        @(posedge rng_clk);
        #1;
        bit_valid  = 1'b0;
        bit_data   = 1'b0;
        ehr.rd_req = 1'b0;
        vn_err     = 1'b0;
    endtask

    task automatic sendBits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, w[31-i], 1'b0, 1'b0);
    endtask

    task automatic readWord(input logic [31:0] w);
        expQ.push_back('{w, cyc});
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        ehr.rd_req = 1'b0;
        repeat (3) @(posedge rng_clk);
        @(negedge rng_clk);
        checkOutput("reset_ehr_valid", 32'(ehr.ehr_valid), 32'd0);
        checkOutput("reset_word_cnt", 32'(ehr.ehr_word_cnt), 32'd0);
        checkOutput("reset_rd_valid", 32'(ehr.rd_valid), 32'd0);
        checkOutput("reset_rd_data", ehr.rd_data, 32'd0);
        checkOutput("reset_state", 32'(dut.state), 32'(IDLE));
        @(posedge rng_clk);
        #1;
        rst_n      = 1'b1;
        rnd_src_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge rng_clk);
        checkOutput("enable_state", 32'(dut.state), 32'(FILL));

        // Reads during FILL are ignored; enable drop discards partial data.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge rng_clk);
        checkOutput("fill_read_rd_valid", 32'(ehr.rd_valid), 32'd0);
        sendBits(32'hFFFF_FFFF, 32);
        sendBits(32'hFF00_0000, 8);
        @(negedge rng_clk);
        checkOutput("partial_word_cnt", 32'(ehr.ehr_word_cnt), 32'd1);
        rnd_src_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge rng_clk);
        checkOutput("drop_state", 32'(dut.state), 32'(IDLE));
        checkOutput("drop_word_cnt", 32'(ehr.ehr_word_cnt), 32'd0);
        rnd_src_en = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Fill and drain with the A5 pattern.
        for (int w = 0; w < 5; w++) sendBits(32'hA5A5_A5A5, 32);
        sendBits(32'hA5A5_A5A5, 31);
        @(negedge rng_clk);
        checkOutput("a5_ehr_valid_191", 32'(ehr.ehr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge rng_clk);
        checkOutput("a5_ehr_valid_192", 32'(ehr.ehr_valid), 32'd1);
        checkOutput("a5_state_full", 32'(dut.state), 32'(FULL));
        checkOutput("a5_word_cnt", 32'(ehr.ehr_word_cnt), 32'd6);
        for (int w = 0; w < 6; w++) readWord(32'hA5A5_A5A5);
        @(negedge rng_clk);
        checkOutput("a5_ehr_valid_end", 32'(ehr.ehr_valid), 32'd0);
        checkOutput("a5_state_end", 32'(dut.state), 32'(FILL));
        checkOutput("a5_word_cnt_end", 32'(ehr.ehr_word_cnt), 32'd0);
        checkOutput("a5_overflow", 32'(ehr.ehr_overflow), 32'd0);

        // Bit ordering plus overflow: extra bits in FULL must not corrupt data.
        for (int w = 0; w < 6; w++) sendBits(ovWords[w], 32);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge rng_clk);
        checkOutput("ov_overflow", 32'(ehr.ehr_overflow), 32'd1);
        checkOutput("ov_word_cnt", 32'(ehr.ehr_word_cnt), 32'd6);
        checkOutput("ov_ehr_valid", 32'(ehr.ehr_valid), 32'd1);
        for (int w = 0; w < 6; w++) readWord(ovWords[w]);

        // vn_err after 70 bits flushes everything collected so far.
        sendBits(32'hFFFF_FFFF, 32);
        sendBits(32'h0000_0000, 32);
        sendBits(32'hFC00_0000, 6);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge rng_clk);
        checkOutput("vn_flag", 32'(ehr.vn_err_flag), 32'd1);
        checkOutput("vn_word_cnt", 32'(ehr.ehr_word_cnt), 32'd0);
        checkOutput("vn_state", 32'(dut.state), 32'(FILL));
        for (int w = 0; w < 5; w++) sendBits(vnWords[w], 32);
        sendBits(vnWords[5], 31);
        @(negedge rng_clk);
        checkOutput("vn_ehr_valid_191", 32'(ehr.ehr_valid), 32'd0);
        applyStimulus(1'b1, vnWords[5][0], 1'b0, 1'b0);
        @(negedge rng_clk);
        checkOutput("vn_ehr_valid_192", 32'(ehr.ehr_valid), 32'd1);
        for (int w = 0; w < 6; w++) readWord(vnWords[w]);

        // Soft reset in the middle of a drain.
        for (int w = 0; w < 6; w++) sendBits(srWords[w], 32);
        for (int w = 0; w < 3; w++) readWord(srWords[w]);
        @(negedge rng_clk);
        checkOutput("sr_state_drain", 32'(dut.state), 32'(DRAIN));
        checkOutput("sr_overflow_pre", 32'(ehr.ehr_overflow), 32'd1);
        rst_trng_logic = 1'b1;
        @(posedge rng_clk);
        #1;
        rst_trng_logic = 1'b0;
        @(negedge rng_clk);
        checkOutput("sr_state", 32'(dut.state), 32'(IDLE));
        checkOutput("sr_ehr_valid", 32'(ehr.ehr_valid), 32'd0);
        checkOutput("sr_overflow", 32'(ehr.ehr_overflow), 32'd0);
        checkOutput("sr_vn_flag", 32'(ehr.vn_err_flag), 32'd0);
        checkOutput("sr_rd_valid", 32'(ehr.rd_valid), 32'd0);
        checkOutput("sr_rd_data", ehr.rd_data, 32'd0);
        checkOutput("sr_word_cnt", 32'(ehr.ehr_word_cnt), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge rng_clk);
        checkOutput("sr_read_ignored", 32'(ehr.rd_valid), 32'd0);

        repeat (4) @(posedge rng_clk);
        @(negedge rng_clk);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
